// File: rtl/regfile_operand_fetch.sv
// Operand fetch stage between decode and execute: drives the register file read IDs,
// waits out its registered read, and returns operands with write-back bypassing.
module regfile_operand_fetch #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ID_W     = 6,
    parameter int unsigned NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ID_W-1:0]   in_rs1,
    input  logic [ID_W-1:0]   in_rs2,
    input  logic [ID_W-1:0]   in_rd,
    input  logic              wb_valid,
    input  logic [ID_W-1:0]   wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic              rf_write,
    output logic [ID_W-1:0]   rf_write_id,
    output logic [DATA_W-1:0] rf_write_data,
    output logic [ID_W-1:0]   rf_read_id1,
    output logic [ID_W-1:0]   rf_read_id2,
    input  logic [DATA_W-1:0] rf_read_data1,
    input  logic [DATA_W-1:0] rf_read_data2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_rs1_val,
    output logic [DATA_W-1:0] out_rs2_val,
    output logic [ID_W-1:0]   out_rd
);

    typedef enum logic [1:0] {IDLE, RD, CAP, VALID} state_t;

    localparam logic [ID_W:0] REG_LIMIT = (ID_W + 1)'(NUM_REGS);

    state_t              state_q, state_d;
    logic [ID_W-1:0]     rs1_q, rs2_q, rd_q;
    logic                byp1_q, byp2_q;
    logic [DATA_W-1:0]   byp1_val_q, byp2_val_q;
    logic                accept;

    function automatic logic id_live(input logic [ID_W-1:0] id);
        return (id != '0) && ({1'b0, id} < REG_LIMIT);
    endfunction

    // Priority: dead ID, same-edge write-back, write-back seen at the read edge, file data.
    function automatic logic [DATA_W-1:0] pick(
        input logic [ID_W-1:0]   id,
        input logic              wb_hit,
        input logic [DATA_W-1:0] wb_val,
        input logic              byp,
        input logic [DATA_W-1:0] byp_val,
        input logic [DATA_W-1:0] rf_val
    );
        if (!id_live(id))  return '0;
        else if (wb_hit)   return wb_val;
        else if (byp)      return byp_val;
        else               return rf_val;
    endfunction

    assign rf_write      = wb_valid & id_live(wb_rd);
    assign rf_write_id   = wb_rd;
    assign rf_write_data = wb_data;
    assign rf_read_id1   = rs1_q;
    assign rf_read_id2   = rs2_q;

    always_comb begin
        state_d  = state_q;
        in_ready = (state_q == IDLE) || (state_q == VALID && out_ready);
        accept   = in_valid && in_ready;
        case (state_q)
            IDLE:    if (in_valid) state_d = RD;
            RD:      state_d = CAP;
            CAP:     state_d = VALID;
            VALID:   if (out_ready) state_d = in_valid ? RD : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            byp1_q      <= 1'b0;
            byp2_q      <= 1'b0;
            byp1_val_q  <= '0;
            byp2_val_q  <= '0;
            out_valid   <= 1'b0;
            out_rs1_val <= '0;
            out_rs2_val <= '0;
            out_rd      <= '0;
        end else begin
            if (accept) begin
                rs1_q  <= in_rs1;
                rs2_q  <= in_rs2;
                rd_q   <= in_rd;
                byp1_q <= 1'b0;
                byp2_q <= 1'b0;
            end
            case (state_q)
                RD: begin
                    // The file's read at this edge races the write; keep the written value.
                    if (wb_valid && wb_rd == rs1_q) begin
                        byp1_q     <= 1'b1;
                        byp1_val_q <= wb_data;
                    end
                    if (wb_valid && wb_rd == rs2_q) begin
                        byp2_q     <= 1'b1;
                        byp2_val_q <= wb_data;
                    end
                end
                CAP: begin
                    out_rs1_val <= pick(rs1_q, wb_valid && wb_rd == rs1_q, wb_data,
                                        byp1_q, byp1_val_q, rf_read_data1);
                    out_rs2_val <= pick(rs2_q, wb_valid && wb_rd == rs2_q, wb_data,
                                        byp2_q, byp2_val_q, rf_read_data2);
                    out_rd      <= rd_q;
                    out_valid   <= 1'b1;
                end
                VALID: begin
                    if (wb_valid && wb_rd == rs1_q && id_live(rs1_q)) out_rs1_val <= wb_data;
                    if (wb_valid && wb_rd == rs2_q && id_live(rs2_q)) out_rs2_val <= wb_data;
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_operand_fetch.sv
// Scoreboard bench for regfile_operand_fetch with a behavioural 32x32 file whose
// read returns garbage when it collides with a same-edge write.
module tb_regfile_operand_fetch;

    localparam logic [31:0] BAD = 32'hBAD0_BAD0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [5:0]  in_rs1, in_rs2, in_rd;
    logic        wb_valid;
    logic [5:0]  wb_rd;
    logic [31:0] wb_data;
    logic        rf_write;
    logic [5:0]  rf_write_id, rf_read_id1, rf_read_id2;
    logic [31:0] rf_write_data, rf_read_data1, rf_read_data2;
    logic        out_valid, out_ready;
    logic [31:0] out_rs1_val, out_rs2_val;
    logic [5:0]  out_rd;

    typedef struct {
        logic [31:0] v1;
        logic [31:0] v2;
        logic [5:0]  rd;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          tests = 0;
    int          failed = 0;
    logic [31:0] mem [32];

    regfile_operand_fetch #(.DATA_W(32), .ID_W(6), .NUM_REGS(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .rf_write(rf_write), .rf_write_id(rf_write_id), .rf_write_data(rf_write_data),
        .rf_read_id1(rf_read_id1), .rf_read_id2(rf_read_id2),
        .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val), .out_rd(out_rd)
    );

    always #5 clk = ~clk;

    initial for (int i = 0; i < 32; i++) mem[i] = 32'h0;

    always @(posedge clk) begin
        if (rf_write) mem[rf_write_id[4:0]] <= rf_write_data;
        rf_read_data1 <= (rf_read_id1 >= 6'd32 || (rf_write && rf_write_id == rf_read_id1))
                         ? BAD : mem[rf_read_id1[4:0]];
        rf_read_data2 <= (rf_read_id2 >= 6'd32 || (rf_write && rf_write_id == rf_read_id2))
                         ? BAD : mem[rf_read_id2[4:0]];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                tests++;
                failed++;
                $display("FAIL unexpected_output: got rd %0d expected no output", out_rd);
            end else begin
                e = sb.pop_front();
                check("sb_rs1_val", out_rs1_val, e.v1);
                check("sb_rs2_val", out_rs2_val, e.v2);
                check("sb_rd", 32'(out_rd), 32'(e.rd));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [5:0] r1, input logic [5:0] r2, input logic [5:0] rd,
                         input logic [31:0] e1, input logic [31:0] e2, input bit push);
        int unsigned n = 0;
        in_valid = 1'b1;
        in_rs1   = r1;
        in_rs2   = r2;
        in_rd    = rd;
        #1;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        if (n == 20) begin
            tests++;
            failed++;
            $display("FAIL accept_timeout: got in_ready 0 expected 1 within 20 cycles");
        end
        if (push) sb.push_back('{v1: e1, v2: e2, rd: rd});
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wb(input logic [5:0] rd, input logic [31:0] d);
        wb_valid = 1'b1;
        wb_rd    = rd;
        wb_data  = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before 100000");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
        wb_valid = 1'b0; wb_rd = '0; wb_data = '0; out_ready = 1'b1;
        #12;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_rd", 32'(out_rd), 0);
        check("rst_rs1_val", out_rs1_val, 0);
        check("rst_rs2_val", out_rs2_val, 0);
        rst_n = 1'b1;
        tick();

        // Basic fetch with latency check.
        wb(5, 32'h1234_5678);
        #1;
        check("wb5_rf_write", 32'(rf_write), 1);
        check("wb5_rf_write_id", 32'(rf_write_id), 5);
        check("wb5_rf_write_data", rf_write_data, 32'h1234_5678);
        tick();
        wb_valid = 1'b0;
        issue(5, 0, 7, 32'h1234_5678, 32'h0, 1);
        check("lat_rd_cycle", 32'(out_valid), 0);
        tick();
        check("lat_cap_cycle", 32'(out_valid), 0);
        tick();
        check("lat_valid_cycle", 32'(out_valid), 1);
        tick();

        // Write-back racing the file read edge.
        wb(9, 32'h1);
        tick();
        wb_valid = 1'b0;
        issue(9, 9, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1);
        wb(9, 32'hDEAD_BEEF);
        tick();
        wb_valid = 1'b0;
        tick(); tick();

        // Write-back on the capture edge.
        wb(3, 32'hA);
        tick();
        wb_valid = 1'b0;
        issue(3, 5, 2, 32'hB, 32'h1234_5678, 1);
        tick();
        wb(3, 32'hB);
        tick();
        wb_valid = 1'b0;
        tick();

        // Backpressure hold with coherent update, then handshake plus new accept.
        out_ready = 1'b0;
        issue(3, 9, 4, 32'hC, 32'hDEAD_BEEF, 1);
        tick(); tick();
        check("hold_valid0", 32'(out_valid), 1);
        check("hold_rs1_pre", out_rs1_val, 32'hB);
        check("hold_rs2_pre", out_rs2_val, 32'hDEAD_BEEF);
        tick();
        check("hold_valid1", 32'(out_valid), 1);
        wb(3, 32'hC);
        tick();
        wb_valid = 1'b0;
        check("hold_rs1_upd", out_rs1_val, 32'hC);
        check("hold_rs2_stable", out_rs2_val, 32'hDEAD_BEEF);
        check("hold_rd_stable", 32'(out_rd), 4);
        tick();
        check("hold_valid3", 32'(out_valid), 1);
        out_ready = 1'b1;
        in_valid = 1'b1; in_rs1 = 5; in_rs2 = 3; in_rd = 6;
        #1;
        check("handoff_in_ready", 32'(in_ready), 1);
        sb.push_back('{v1: 32'h1234_5678, v2: 32'hC, rd: 6'd6});
        tick();
        in_valid = 1'b0;
        check("handoff_out_valid", 32'(out_valid), 0);
        check("handoff_rd_state", 32'(in_ready), 0);
        tick(); tick(); tick();

        // Dropped write-backs and out-of-range sources.
        wb(0, 32'hFFFF_FFFF);
        #1;
        check("wb0_dropped", 32'(rf_write), 0);
        tick();
        wb(33, 32'hFFFF_FFFF);
        #1;
        check("wb33_dropped", 32'(rf_write), 0);
        tick();
        wb_valid = 1'b0;
        issue(40, 33, 8, 32'h0, 32'h0, 1);
        wb(40, 32'h5555_5555);
        #1;
        check("wb40_dropped", 32'(rf_write), 0);
        tick();
        wb_valid = 1'b0;
        tick(); tick();

        // Reset while holding output, then reset during CAP.
        out_ready = 1'b0;
        issue(9, 5, 10, 32'h0, 32'h0, 0);
        tick(); tick();
        check("pre_rst_valid", 32'(out_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(out_valid), 0);
        check("async_rst_rd", 32'(out_rd), 0);
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        issue(5, 3, 9, 32'h0, 32'h0, 0);
        tick();
        check("cap_in_ready", 32'(in_ready), 0);
        #2 rst_n = 1'b0;
        #1;
        check("cap_rst_in_ready", 32'(in_ready), 1);
        #2 rst_n = 1'b1;
        tick();
        check("post_rst_in_ready", 32'(in_ready), 1);
        for (int i = 0; i < 3; i++) begin
            check("post_rst_no_output", 32'(out_valid), 0);
            tick();
        end

        issue(9, 0, 31, 32'hDEAD_BEEF, 32'h0, 1);
        tick(); tick(); tick(); tick();
        check("scoreboard_drained", 32'(sb.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/regfile_operand_fetch.md
Name: regfile_operand_fetch

Overview:
- Initiator for the 32x32 register file. Accepts decoded instructions (rs1/rs2/rd), drives the file's read IDs, waits out its one-cycle registered read, and returns operand values with a valid/ready handshake.
- Forwards execute-stage write-backs to the file's write port. Bypasses same-edge write-backs, because the file's write and read edges race and return indeterminate data.
- Sits between decode and execute.

Parameters:
DATA_W, 32, operand/data width
ID_W, 6, register ID width
NUM_REGS, 32, valid IDs are 0..NUM_REGS-1; ID 0 reads as zero

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  instruction request valid
in_ready  out  1  fetcher can accept request
in_rs1  in  ID_W  source register 1 ID
in_rs2  in  ID_W  source register 2 ID
in_rd  in  ID_W  destination ID, passed through
wb_valid  in  1  write-back request (always accepted)
wb_rd  in  ID_W  write-back destination ID
wb_data  in  DATA_W  write-back data
rf_write  out  1  register file write enable
rf_write_id  out  ID_W  register file write ID
rf_write_data  out  DATA_W  register file write data
rf_read_id1  out  ID_W  register file read ID 1
rf_read_id2  out  ID_W  register file read ID 2
rf_read_data1  in  DATA_W  register file read data 1 (registered in file)
rf_read_data2  in  DATA_W  register file read data 2
out_valid  out  1  operands valid
out_ready  in  1  consumer accepts operands
out_rs1_val  out  DATA_W  operand 1 value
out_rs2_val  out  DATA_W  operand 2 value
out_rd  out  ID_W  destination ID of the held instruction

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - out_valid=0; out_rs1_val=out_rs2_val=0; out_rd=0.
  - Latched IDs=0; bypass flags cleared.
  - Reset mid-operation discards the in-flight instruction; no output is produced for it.
- Write path is combinational pass-through:
  - rf_write = wb_valid & wb_rd!=0 & wb_rd<NUM_REGS.
  - rf_write_id=wb_rd; rf_write_data=wb_data.
  - Out-of-range or ID-0 write-backs are dropped.
- rf_read_id1/2 are driven from the latched rs1/rs2 registers; they hold their value outside RD.
- FSM states:
  - IDLE: in_ready=1. On in_valid: latch rs1/rs2/rd, go to RD.
  - RD: the file samples the read IDs at the closing edge (E1). For each source, if wb_valid and wb_rd equals the latched ID, set byp flag and capture wb_data. Go to CAP.
  - CAP: rf_read_data valid. At the closing edge (E2), per operand:
    - zero if ID==0 or ID>=NUM_REGS;
    - else wb_data if wb at E2 matches;
    - else the bypass value if byp set;
    - else rf_read_data.
    - out_rd=latched rd; out_valid=1; go to VALID.
  - VALID: out_valid=1; outputs held stable.
    - Any wb_valid matching a held nonzero in-range source ID updates that operand at the edge, so held operands stay coherent.
    - If out_ready: out_valid drops. If in_valid is also high, accept the new request (go to RD); otherwise go to IDLE.
- in_ready = (state==IDLE) | (state==VALID & out_ready).
- Latency: accept edge to out_valid is 2 cycles (out_valid high in the 3rd cycle after acceptance). Throughput is one instruction per 3 cycles.
- Both sources may name the same register; both receive identical values.
- A wb to rd while that instruction is in flight has no special effect beyond the bypass rules above.

Test Plan:
- Reset, write-back r5=0x1234_5678 at idle, request rs1=5 rs2=0 rd=7 -> rf_write=1 id 5 in the wb cycle; out_valid 3rd cycle after accept; out_rs1_val=0x12345678, out_rs2_val=0, out_rd=7.
- Request rs1=rs2=9 with wb r9=0xDEAD_BEEF on the RD-closing edge (r9 previously 0x1) -> both operands 0xDEADBEEF.
- Request rs1=3 (holds 0xA), wb r3=0xB on the CAP-closing edge -> out_rs1_val=0xB.
- Hold out_ready=0 for 4 cycles with wb r3=0xC mid-hold -> out_valid stays 1, out_rs1_val changes to 0xC after that edge, others stable; out_ready=1 with in_valid=1 -> in_ready=1 same cycle, next request enters RD.
- Request rs1=40 (out of range), wb to rd 0 and rd 33 -> out_rs1_val=0; rf_write=0 for both write-backs.
- Assert rst_n=0 during CAP -> out_valid=0 immediately (async), state IDLE, in_ready=1 after release, no output for the dropped request.
